rom_dl_seq: RTL

- Sequences the ROM download from hps_io into the arcade core's dn_addr/dn_data/dn_wr port.
- Owns the core reset: holds the core in reset while no valid image is present, during a download, and for a fixed stretch after a download or a user reset.
- Validates the image length and rejects out-of-range writes.
- Sits in emu between hps_io and the core.

---
 rtl/rom_dl_if.sv | 24 ++
 rtl/rom_dl_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rom_dl_if.sv
// ROM download bus between hps_io and the download sequencer.
// The master side is hps_io, which drives the ioctl byte stream.
// The slave side is the sequencer, which drives the core write port.
interface rom_dl_if #(
   parameter int AW = 16
) ();
   logic          ioctl_download;
   logic          ioctl_wr;
   logic [24:0]   ioctl_addr;
   logic [7:0]    ioctl_dout;
   logic [AW-1:0] dn_addr;
   logic [7:0]    dn_data;
   logic          dn_wr;

   modport master (
      output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
      input  dn_addr, dn_data, dn_wr
   );

   modport slave (
      input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
      output dn_addr, dn_data, dn_wr
   );
endinterface

// File: rtl/rom_dl_seq.sv
// ROM download sequencer. It forwards in-range ioctl bytes to the core
// write port, one cycle late. It also checks the image length and
// keeps the core in reset until a valid image has been loaded and the
// post-load reset stretch has elapsed.
module rom_dl_seq #(
   parameter int ROM_SIZE = 32768,
   parameter int RST_HOLD = 16,
   parameter int AW       = 16
) (
   input  logic        clk_sys,
   input  logic        reset,
   rom_dl_if.slave     dl,
   input  logic        user_reset,
   output logic        core_reset,
   output logic        rom_valid,
   output logic        dl_error,
   output logic [24:0] byte_count
);
   localparam int          CW         = $clog2(RST_HOLD + 1);
   localparam logic [24:0] ROM_SIZE_W = 25'(ROM_SIZE);
   localparam logic [24:0] COUNT_MAX  = {25{1'b1}};
   localparam logic [CW-1:0] HOLD_LOAD = CW'(RST_HOLD);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO  = CW'(0);

   typedef enum logic [2:0] {
      ST_EMPTY = 3'd0,
      ST_LOAD  = 3'd1,
      ST_CHECK = 3'd2,
      ST_HOLD  = 3'd3,
      ST_RUN   = 3'd4
   } state_t;

   state_t        state_r, state_s;
   logic [CW-1:0] hold_cnt_r, hold_cnt_s;
   logic          dl_q_r;
   logic          armed_r;      // a low level of ioctl_download has been seen since reset
   logic          overflow_r;
   logic          load_entry_s;
   logic          dl_rise_s, dl_fall_s;
   logic          wr_window_s, wr_ok_s, wr_oob_s;
   logic          image_ok_s;
   logic [AW-1:0] dn_addr_r;
   logic [7:0]    dn_data_r;
   logic          dn_wr_r;
   logic          core_reset_r, rom_valid_r, dl_error_r;
   logic [24:0]   byte_count_r;

   // A rising edge only counts once the line has been seen low. This way a
   // download that was already active when reset was released is ignored.
   assign dl_rise_s = dl.ioctl_download & ~dl_q_r & armed_r;
   assign dl_fall_s = ~dl.ioctl_download & dl_q_r;

   // A strobe in the same cycle as the falling edge still belongs to the download.
   assign wr_window_s = dl.ioctl_wr & (dl.ioctl_download | dl_q_r) & (state_r == ST_LOAD);
   assign wr_ok_s     = wr_window_s & (dl.ioctl_addr < ROM_SIZE_W);
   assign wr_oob_s    = wr_window_s & ~(dl.ioctl_addr < ROM_SIZE_W);
   assign image_ok_s  = (byte_count_r == ROM_SIZE_W) & ~overflow_r;

   // Next-state and reset-stretch counter logic
   always_comb begin
      state_s      = state_r;
      hold_cnt_s   = hold_cnt_r;
      load_entry_s = 1'b0;
      case (state_r)
         ST_EMPTY: begin
            if (dl_rise_s) begin
               state_s      = ST_LOAD;
               load_entry_s = 1'b1;
            end else begin
               state_s = ST_EMPTY;
            end
         end
         ST_LOAD: begin
            if (dl_fall_s) begin
               state_s = ST_CHECK;
            end else begin
               state_s = ST_LOAD;
            end
         end
         ST_CHECK: begin
            if (image_ok_s) begin
               state_s    = ST_HOLD;
               hold_cnt_s = HOLD_LOAD;
            end else begin
               state_s = ST_EMPTY;
            end
         end
         ST_HOLD: begin
            if (dl_rise_s) begin
               state_s      = ST_LOAD;
               load_entry_s = 1'b1;
            end else if (user_reset) begin
               hold_cnt_s = HOLD_LOAD;
            end else if (hold_cnt_r <= CNT_ONE) begin
               state_s    = ST_RUN;
               hold_cnt_s = CNT_ZERO;
            end else begin
               hold_cnt_s = hold_cnt_r - CNT_ONE;
            end
         end
         ST_RUN: begin
            if (dl_rise_s) begin
               state_s      = ST_LOAD;
               load_entry_s = 1'b1;
            end else if (user_reset) begin
               state_s    = ST_HOLD;
               hold_cnt_s = HOLD_LOAD;
            end else begin
               state_s = ST_RUN;
            end
         end
         default: begin
            state_s    = ST_EMPTY;
            hold_cnt_s = CNT_ZERO;
         end
      endcase
   end

   // State register, download edge tracking and core reset output
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_r      <= ST_EMPTY;
         hold_cnt_r   <= CNT_ZERO;
         dl_q_r       <= 1'b0;
         armed_r      <= 1'b0;
         core_reset_r <= 1'b1;
      end else begin
         state_r      <= state_s;
         hold_cnt_r   <= hold_cnt_s;
         dl_q_r       <= dl.ioctl_download;
         armed_r      <= armed_r | ~dl.ioctl_download;
         core_reset_r <= (state_s != ST_RUN);
      end
   end

   // Core write port: one registered strobe per accepted byte
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         dn_addr_r <= {AW{1'b0}};
         dn_data_r <= 8'd0;
         dn_wr_r   <= 1'b0;
      end else begin
         dn_wr_r <= wr_ok_s;
         if (wr_ok_s) begin
            dn_addr_r <= dl.ioctl_addr[AW-1:0];
            dn_data_r <= dl.ioctl_dout;
         end
      end
   end

   // Download bookkeeping: byte count, overflow and the verdict taken in CHECK
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         byte_count_r <= 25'd0;
         overflow_r   <= 1'b0;
         rom_valid_r  <= 1'b0;
         dl_error_r   <= 1'b0;
      end else if (load_entry_s) begin
         byte_count_r <= 25'd0;
         overflow_r   <= 1'b0;
         rom_valid_r  <= 1'b0;
         dl_error_r   <= 1'b0;
      end else begin
         if (wr_ok_s && (byte_count_r != COUNT_MAX)) begin
            byte_count_r <= byte_count_r + 25'd1;
         end
         if (wr_oob_s) begin
            overflow_r <= 1'b1;
         end
         if (state_r == ST_CHECK) begin
            rom_valid_r <= image_ok_s;
            dl_error_r  <= ~image_ok_s;
         end
      end
   end

   assign dl.dn_addr  = dn_addr_r;
   assign dl.dn_data  = dn_data_r;
   assign dl.dn_wr    = dn_wr_r;
   assign core_reset  = core_reset_r;
   assign rom_valid   = rom_valid_r;
   assign dl_error    = dl_error_r;
   assign byte_count  = byte_count_r;
endmodule
